btn_debounce: RTL

- Conditioning stage that sits directly upstream of the lab storage elements (latch / async-reset DFF / sync-reset DFF).
- Takes a raw, asynchronous, bouncing switch or button input and synchronises it into clk.
- Filters out bounce and drives a clean registered level `d_out`, which feeds the storage elements' `d` input, plus single-cycle edge pulses.

---
 rtl/btn_debounce_pkg.sv | 23 ++
 rtl/btn_debounce_if.sv | 28 ++
 rtl/btn_debounce_sync_ff_chain.sv | 28 ++
 rtl/btn_debounce.sv | 122 ++++++++++++
 4 files changed

// File: rtl/btn_debounce_pkg.sv
// Shared types and defaults for the button conditioning stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package btn_debounce_pkg;

  // Bit 0 set marks the two qualification states.
  typedef enum logic [1:0] {
    IDLE_LO = 2'b00,
    WAIT_HI = 2'b01,
    IDLE_HI = 2'b10,
    WAIT_LO = 2'b11
  } db_state_t;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 10;
  localparam int DEF_CNT_W           = 4;

  // True while a candidate transition is being qualified.
  function automatic logic is_wait(db_state_t st);
    return (st == WAIT_HI) || (st == WAIT_LO);
  endfunction

endpackage

// File: rtl/btn_debounce_if.sv
// Raw button input and conditioned outputs bundled for the debounce stage.
// Latency: n/a (wiring only).
// Backpressure: none; every signal is a plain level or pulse.
interface btn_debounce_if;
  logic btn_in;
  logic d_out;
  logic rise_pulse;
  logic fall_pulse;
  logic busy;

  // Stimulus / consumer side: drives the raw switch, observes the clean outputs.
  modport master (
    output btn_in,
    input  d_out,
    input  rise_pulse,
    input  fall_pulse,
    input  busy
  );

  // Debouncer side.
  modport slave (
    input  btn_in,
    output d_out,
    output rise_pulse,
    output fall_pulse,
    output busy
  );
endinterface

// File: rtl/btn_debounce_sync_ff_chain.sv
// Multi-flop synchronizer for an asynchronous single-bit input.
// Latency: STAGES clk cycles from d to q.
// Backpressure: none; d is sampled every cycle.
module sync_ff_chain
  import btn_debounce_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the raw input through the chain; reset clears every stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/btn_debounce.sv
// Synchronises and debounces a bouncing button into a clean level plus edge pulses.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES clk edges from a stable input change to d_out.
// Backpressure: none; the input is sampled every cycle and outputs are free-running.
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input logic           clk,
  input logic           rst,
  btn_debounce_if.slave io
);

  // The entry cycle into WAIT already counts as one stable cycle, so the
  // last qualifying cycle is reached when cnt equals DEBOUNCE_CYCLES-1.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             s;
  db_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             d_out_q, d_out_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             busy_q;

  sync_ff_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (io.btn_in),
    .q   (s)
  );

  // Next-state, counter and output decode; any return of s to the current
  // level during WAIT drops back to IDLE and restarts qualification.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    d_out_d = d_out_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      IDLE_LO: begin
        if (s) begin
          state_d = WAIT_HI;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      WAIT_HI: begin
        if (!s) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
        end else if (cnt_q < CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          state_d = IDLE_HI;
          cnt_d   = '0;
          d_out_d = 1'b1;
          rise_d  = 1'b1;
        end
      end
      IDLE_HI: begin
        if (!s) begin
          state_d = WAIT_LO;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      WAIT_LO: begin
        if (s) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
        end else if (cnt_q < CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          state_d = IDLE_LO;
          cnt_d   = '0;
          d_out_d = 1'b0;
          fall_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE_LO;
        cnt_d   = '0;
        d_out_d = 1'b0;
      end
    endcase
  end

  // State, counter and registered outputs; reset wins over everything and
  // never emits a pulse even when it pulls d_out low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE_LO;
      cnt_q   <= '0;
      d_out_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_out_q <= d_out_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= is_wait(state_d);
    end
  end

  assign io.d_out      = d_out_q;
  assign io.rise_pulse = rise_q;
  assign io.fall_pulse = fall_q;
  assign io.busy       = busy_q;

endmodule
